morse_tx: RTL and testbench
===========================

MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 25000000, meaning clocks per Morse unit (0.5 s at 50 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter DASH_UNITS, default 3, meaning the dash length in units; legal range is 2 or more.
REQ-003 SHALL have parameter GAP_UNITS, default 1, meaning the intra-letter gap in units; legal range is 1 or more.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port SW_i, input, 5 bits: letter index, 0 = A through 25 = Z.
REQ-007 SHALL have port start_i, input, 1 bit, synchronous: its rising edge requests transmission.
REQ-008 SHALL have port abort_i, input, 1 bit, synchronous and level-sensitive: it cancels the current transmission.
REQ-009 SHALL have port led_o, output, 1 bit: Morse output, 1 during a mark.
REQ-010 SHALL have port busy_o, output, 1 bit: high while a transmission is in progress.
REQ-011 SHALL have port done_o, output, 1 bit: one-cycle pulse when a letter completes.
REQ-012 SHALL have port err_o, output, 1 bit: one-cycle pulse when a start request carries an index above 25.

Function
REQ-013 SHALL detect a start as start_i=1 in cycle N with start_i=0 in cycle N-1, using a registered previous value.
REQ-014 SHALL sample SW_i only in the start-edge cycle; later SW_i changes have no effect on the letter in progress.
REQ-015 SHALL hold the ITU Morse table for A-Z, giving a 4-bit code (1 = dash) and a 3-bit length of 1..4; the first symbol is code[0].
REQ-016 SHALL implement an FSM with states IDLE, MARK and SPACE.
REQ-017 SHALL, on a valid start edge in IDLE in cycle N, be in MARK from cycle N+1 with led_o=1 and busy_o=1.
REQ-018 SHALL hold MARK for exactly UNIT_CYCLES cycles for a dot and DASH_UNITS*UNIT_CYCLES cycles for a dash.
REQ-019 SHALL go from MARK to SPACE when symbols remain; SPACE lasts GAP_UNITS*UNIT_CYCLES cycles with led_o=0, then returns to MARK for the next symbol.
REQ-020 SHALL go from MARK of the last symbol directly to IDLE, with no trailing space.
REQ-021 SHALL pulse done_o in the first IDLE cycle after the last mark; busy_o=0 in that same cycle.
REQ-022 SHALL, on a start edge with SW_i above 25, pulse err_o in cycle N+1 and stay in IDLE with led_o=0.
REQ-023 SHALL ignore start edges while busy_o=1, without queuing them.
REQ-024 SHALL, on abort_i=1 while busy, be in IDLE with led_o=0 and busy_o=0 at the next cycle, with no done_o pulse.
REQ-025 SHALL give abort_i priority over a simultaneous start edge; the start edge is discarded.
REQ-026 SHALL use a unit timer sized to ceil(log2(DASH_UNITS*UNIT_CYCLES+1)) bits that never wraps inside a phase.

Reset
REQ-027 SHALL, while rst_ni=0, hold state=IDLE, led_o=0, busy_o=0, done_o=0 and err_o=0, and clear the timer, symbol counter and start-edge register.
REQ-028 SHALL, on reset mid-transmission, abandon the transmission immediately with no done_o pulse.
REQ-029 SHALL, when start_i is held high through reset release, produce no start.

Configuration
REQ-030 SHALL, with MORSE_BEACON_EN defined, replace IDLE after the last mark with a 7-unit word gap (led_o=0, busy_o=1), then restart the same latched letter indefinitely.
REQ-031 SHALL, with MORSE_BEACON_EN defined, pulse done_o at each letter completion, and stop the beacon only by abort_i or reset.
REQ-032 SHALL, without MORSE_BEACON_EN, transmit one letter per start edge per REQ-020/REQ-021.

Structure
REQ-033 SHALL place the following in package morse_pkg: the state enum, the 26-entry code/length table as a function, and the constants LETTER_MAX=25, MAX_SYMBOLS=4 and WORD_GAP_UNITS=7.
REQ-034 SHALL implement the unit timer as sub-module morse_unit_timer: load a count, assert expire on the final cycle.

Verification (all with UNIT_CYCLES=4, DASH_UNITS=3, GAP_UNITS=1)
REQ-035 SHALL verify: SW_i=0 (A) with a start edge -> led_o high 4 cycles, low 4, high 12; done_o pulses once at cycle 21; busy_o spans 20 cycles.
REQ-036 SHALL verify: SW_i=4 (E) -> led_o high 4 cycles, then done_o; and SW_i=27 -> err_o pulses once, led_o stays 0.
REQ-037 SHALL verify: SW_i=16 (Q, --.-) with abort_i at the 6th cycle of the second dash -> led_o=0 next cycle, no done_o.
REQ-038 SHALL verify: a second start edge and SW_i change during letter B -> B completes unchanged and no second letter follows.
REQ-039 SHALL verify: rst_ni low mid-dash -> all outputs 0 asynchronously; start_i held high across reset release -> no transmission.
REQ-040 SHALL verify: with MORSE_BEACON_EN and letter T -> high 12 cycles, low 28, high 12, and so on, with done_o every 40 cycles until abort_i.

Source files
------------

// File: rtl/morse_pkg.sv
// ============================================================================
// Module      : morse_pkg
// Description : Shared definitions for the Morse letter transmitter:
//               FSM state type, letter/symbol constants and the ITU A-Z
//               code table (code bit 0 is the first symbol, 1 = dash).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  localparam int LETTER_MAX     = 25;
  localparam int MAX_SYMBOLS    = 4;
  localparam int WORD_GAP_UNITS = 7;

  typedef struct packed {
    logic [2:0] len;   // number of symbols, 1..4
    logic [3:0] code;  // bit i = symbol i, 1 = dash
  } morse_entry_t;

  function automatic morse_entry_t morse_lookup(input logic [4:0] idx);
    morse_entry_t e;
    case (idx)
      5'd0:    e = '{3'd2, 4'b0010}; // A .-
      5'd1:    e = '{3'd4, 4'b0001}; // B -...
      5'd2:    e = '{3'd4, 4'b0101}; // C -.-.
      5'd3:    e = '{3'd3, 4'b0001}; // D -..
      5'd4:    e = '{3'd1, 4'b0000}; // E .
      5'd5:    e = '{3'd4, 4'b0100}; // F ..-.
      5'd6:    e = '{3'd3, 4'b0011}; // G --.
      5'd7:    e = '{3'd4, 4'b0000}; // H ....
      5'd8:    e = '{3'd2, 4'b0000}; // I ..
      5'd9:    e = '{3'd4, 4'b1110}; // J .---
      5'd10:   e = '{3'd3, 4'b0101}; // K -.-
      5'd11:   e = '{3'd4, 4'b0010}; // L .-..
      5'd12:   e = '{3'd2, 4'b0011}; // M --
      5'd13:   e = '{3'd2, 4'b0001}; // N -.
      5'd14:   e = '{3'd3, 4'b0111}; // O ---
      5'd15:   e = '{3'd4, 4'b0110}; // P .--.
      5'd16:   e = '{3'd4, 4'b1011}; // Q --.-
      5'd17:   e = '{3'd3, 4'b0010}; // R .-.
      5'd18:   e = '{3'd3, 4'b0000}; // S ...
      5'd19:   e = '{3'd1, 4'b0001}; // T -
      5'd20:   e = '{3'd3, 4'b0100}; // U ..-
      5'd21:   e = '{3'd4, 4'b1000}; // V ...-
      5'd22:   e = '{3'd3, 4'b0110}; // W .--
      5'd23:   e = '{3'd4, 4'b1001}; // X -..-
      5'd24:   e = '{3'd4, 4'b1101}; // Y -.--
      5'd25:   e = '{3'd4, 4'b0011}; // Z --..
      default: e = '{3'd0, 4'b0000};
    endcase
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/morse_unit_timer.sv
// ============================================================================
// Module      : morse_unit_timer
// Description : Phase timer. A load of N in the cycle before a phase makes
//               expire_o assert in the N-th (final) cycle of that phase.
//               The counter parks at zero and never wraps.
// Ports       : clk_i    - clock
//               rst_ni   - asynchronous active-low reset (clears count)
//               load_i   - load count_i for the phase starting next cycle
//               count_i  - phase length in cycles (>= 1)
//               expire_o - high in the final cycle of the loaded phase
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_unit_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (load_i) begin
      // Phase begins next cycle, so the first phase cycle sees N-1.
      r_cnt <= count_i - WIDTH'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign expire_o = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/morse_tx.sv
// ============================================================================
// Module      : morse_tx
// Description : Single-letter Morse transmitter. A rising edge on start_i
//               latches SW_i (0=A..25=Z) and plays the letter on led_o.
//               Optional build macro MORSE_BEACON_EN: after each letter a
//               7-unit word gap follows and the latched letter repeats until
//               abort_i or reset.
// Ports       : clk_i   - clock (rising edge)
//               rst_ni  - asynchronous active-low reset
//               SW_i    - letter index, sampled only on the start edge
//               start_i - rising edge requests a transmission
//               abort_i - level, cancels transmission (beats start)
//               led_o   - 1 during a mark
//               busy_o  - 1 while transmitting
//               done_o  - 1-cycle pulse at letter completion
//               err_o   - 1-cycle pulse on a start with index > 25
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25000000,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] SW_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       led_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int c_dash_cyc = DASH_UNITS * UNIT_CYCLES;
  localparam int c_gap_cyc  = GAP_UNITS * UNIT_CYCLES;
`ifdef MORSE_BEACON_EN
  localparam int c_word_cyc  = WORD_GAP_UNITS * UNIT_CYCLES;
  localparam int c_space_max = (c_gap_cyc > c_word_cyc) ? c_gap_cyc : c_word_cyc;
`else
  localparam int c_space_max = c_gap_cyc;
`endif
  // Timer covers the dash and also any longer space so no phase wraps.
  localparam int c_phase_max = (c_dash_cyc > c_space_max) ? c_dash_cyc : c_space_max;
  localparam int c_tw        = $clog2(c_phase_max + 1);
  localparam int c_sym_w     = $clog2(MAX_SYMBOLS);

  localparam logic [c_tw-1:0] c_dot_len  = c_tw'(UNIT_CYCLES);
  localparam logic [c_tw-1:0] c_dash_len = c_tw'(c_dash_cyc);
  localparam logic [c_tw-1:0] c_gap_len  = c_tw'(c_gap_cyc);
`ifdef MORSE_BEACON_EN
  localparam logic [c_tw-1:0] c_word_len = c_tw'(c_word_cyc);
`endif

  state_t               r_state, w_state_nxt;
  logic                 r_start_d, r_start_arm;
  logic [3:0]           r_code;
  logic [2:0]           r_len;
  logic [c_sym_w-1:0]   r_sym, w_sym_nxt, w_sym_adv;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_word, w_word_nxt;
  logic                 w_latch;
  logic                 w_load;
  logic [c_tw-1:0]      w_load_val;
  logic                 w_expire;
  logic                 w_start_edge;
  logic                 w_last_sym;
  morse_entry_t         w_entry;

  // r_start_arm stays low until start_i has been seen low after reset, so a
  // start held high across reset release is not taken as an edge.
  assign w_start_edge = start_i & ~r_start_d & r_start_arm;
  assign w_entry      = morse_lookup(SW_i);
  assign w_last_sym   = ({1'b0, r_sym} == (r_len - 3'd1));
  // After a word gap the letter restarts from its first symbol.
  assign w_sym_adv    = r_word ? '0 : r_sym + c_sym_w'(1);

  morse_unit_timer #(
    .WIDTH(c_tw)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (w_load),
    .count_i (w_load_val),
    .expire_o(w_expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_latch     = 1'b0;
    w_sym_nxt   = r_sym;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_word_nxt  = r_word;
    case (r_state)
      ST_IDLE: begin
        if (!abort_i && w_start_edge) begin
          if (SW_i > 5'(LETTER_MAX)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_MARK;
            w_sym_nxt   = '0;
            w_word_nxt  = 1'b0;
            w_load      = 1'b1;
            w_load_val  = w_entry.code[0] ? c_dash_len : c_dot_len;
          end
        end
      end
      ST_MARK: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
          w_word_nxt  = 1'b0;
        end else if (w_expire) begin
          if (w_last_sym) begin
            w_done_nxt  = 1'b1;
`ifdef MORSE_BEACON_EN
            w_state_nxt = ST_SPACE;
            w_word_nxt  = 1'b1;
            w_load      = 1'b1;
            w_load_val  = c_word_len;
`else
            w_state_nxt = ST_IDLE;
`endif
          end else begin
            w_state_nxt = ST_SPACE;
            w_word_nxt  = 1'b0;
            w_load      = 1'b1;
            w_load_val  = c_gap_len;
          end
        end
      end
      ST_SPACE: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
          w_word_nxt  = 1'b0;
        end else if (w_expire) begin
          w_state_nxt = ST_MARK;
          w_sym_nxt   = w_sym_adv;
          w_word_nxt  = 1'b0;
          w_load      = 1'b1;
          w_load_val  = r_code[w_sym_adv] ? c_dash_len : c_dot_len;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_start_d   <= 1'b0;
      r_start_arm <= 1'b0;
      r_code      <= '0;
      r_len       <= '0;
      r_sym       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_word      <= 1'b0;
    end else begin
      r_start_d   <= start_i;
      r_start_arm <= r_start_arm | ~start_i;
      if (w_latch) begin
        r_code <= w_entry.code;
        r_len  <= w_entry.len;
      end
      r_sym  <= w_sym_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      r_word <= w_word_nxt;
    end
  end

  assign led_o  = (r_state == ST_MARK);
  assign busy_o = (r_state != ST_IDLE);
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_morse_tx.sv
// ============================================================================
// Module      : tb_morse_tx
// Description : Self-checking bench for morse_tx (UNIT_CYCLES=4,
//               DASH_UNITS=3, GAP_UNITS=1). Expected LED waveforms come
//               from dot/dash strings expanded with the timing rules.
//               With MORSE_BEACON_EN defined only the beacon sequence runs.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_tx;

  localparam int UNIT = 4;
  localparam int DASH = 3;
  localparam int GAP  = 1;

  logic       clk;
  logic       rst_ni;
  logic [4:0] SW_i;
  logic       start_i;
  logic       abort_i;
  logic       led_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_checks = 0;
  int n_errors = 0;

  bit exp_q[$];

  string c_morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                         "....", "..", ".---", "-.-", ".-..", "--", "-.",
                         "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                         "...-", ".--", "-..-", "-.--", "--.."};

  morse_tx #(
    .UNIT_CYCLES(UNIT),
    .DASH_UNITS (DASH),
    .GAP_UNITS  (GAP)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .SW_i   (SW_i),
    .start_i(start_i),
    .abort_i(abort_i),
    .led_o  (led_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected led_o per cycle from the dot/dash string of one letter.
  function automatic void build_wave(input int idx);
    string s;
    exp_q.delete();
    s = c_morse[idx];
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0)
        for (int k = 0; k < GAP * UNIT; k++) exp_q.push_back(1'b0);
      for (int k = 0; k < ((s.getc(i) == 8'h2D) ? DASH * UNIT : UNIT); k++)
        exp_q.push_back(1'b1);
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_led"},  led_o,  0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"},  err_o,  0);
  endtask

  task automatic send_letter(input int idx, input bit disturb, input int abort_at);
    int total;
    build_wave(idx);
    total = exp_q.size();
    SW_i    = 5'(idx);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < total; i++) begin
      check("tx_led",  led_o,  exp_q[i]);
      check("tx_busy", busy_o, 1);
      check("tx_done", done_o, 0);
      if (disturb && i == total / 2) begin
        SW_i    = 5'($urandom);
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (abort_at == i + 1) begin
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_idle("abort");
        repeat (4) begin
          step();
          check_idle("post_abort");
        end
        return;
      end
      step();
    end
    start_i = 1'b0;
    check("end_done", done_o, 1);
    check("end_busy", busy_o, 0);
    check("end_led",  led_o,  0);
    check("end_err",  err_o,  0);
    repeat (3) begin
      step();
      check_idle("after_letter");
    end
  endtask

  task automatic send_invalid(input int idx);
    SW_i    = 5'(idx);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("err_pulse", err_o,  1);
    check("err_led",   led_o,  0);
    check("err_busy",  busy_o, 0);
    repeat (3) begin
      step();
      check_idle("err_after");
    end
  endtask

  initial begin
    rst_ni  = 1'b0;
    SW_i    = '0;
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) step();
    check_idle("reset");
    rst_ni = 1'b1;
    step();
    check_idle("post_reset");

`ifdef MORSE_BEACON_EN
    // Letter T repeats: 12 high, 28 low, done_o at the first low cycle.
    SW_i    = 5'd19;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < DASH * UNIT + 7 * UNIT; c++) begin
        check("bcn_led",  led_o,  (c < DASH * UNIT) ? 1 : 0);
        check("bcn_busy", busy_o, 1);
        check("bcn_done", done_o, (c == DASH * UNIT) ? 1 : 0);
        step();
      end
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_idle("bcn_abort");
    repeat (5) begin
      step();
      check_idle("bcn_stopped");
    end
`else
    send_letter(0, 1'b0, 0);     // A
    send_letter(4, 1'b0, 0);     // E
    send_invalid(27);
    send_letter(1, 1'b1, 0);     // B with SW_i change and extra start edge
    send_letter(16, 1'b0, 22);   // Q, abort in 6th cycle of second dash

    // Abort together with a start edge in IDLE: the start is dropped.
    SW_i    = 5'd0;
    start_i = 1'b1;
    abort_i = 1'b1;
    step();
    start_i = 1'b0;
    abort_i = 1'b0;
    check_idle("abort_prio");
    step();
    check_idle("abort_prio2");

    for (int k = 0; k < 6; k++)
      send_letter(int'($urandom_range(0, 25)), bit'($urandom_range(0, 1)), 0);
    for (int k = 0; k < 2; k++)
      send_invalid(int'($urandom_range(26, 31)));

    // Reset in the middle of a dash, start_i held high through release.
    SW_i    = 5'd19;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (4) step();
    check("pre_rst_led", led_o, 1);
    rst_ni = 1'b0;
    #2;
    check_idle("async_rst");
    start_i = 1'b1;
    step();
    step();
    rst_ni = 1'b1;
    repeat (6) begin
      step();
      check_idle("held_start");
    end
    start_i = 1'b0;
    step();
    send_letter(int'($urandom_range(0, 25)), 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
